montgomery_exp: RTL
===================

Name: montgomery_exp

Overview:
- Modular exponentiation controller, result = in_x^in_e mod in_m, using left-to-right square-and-multiply.
- Sits directly upstream of the 512-bit montgomery multiplier. Issues every multiplication to it over the mul_* handshake and consumes its result/done.
- Handles entry into and exit from the Montgomery domain, so callers supply plain-domain operands plus precomputed R mod M and R^2 mod M (R = 2^WIDTH).

Parameters:
WIDTH, 512, operand/modulus width; must match the multiplier.
E_WIDTH, 512, exponent width in bits.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset (fixed polarity; codebase base name without the n suffix).
start  in  1  one-cycle request; sampled only in IDLE.
in_x  in  WIDTH  base, plain domain, < in_m.
in_e  in  E_WIDTH  exponent.
in_m  in  WIDTH  odd modulus, > 1.
in_r  in  WIDTH  R mod M.
in_r2  in  WIDTH  R^2 mod M.
busy  out  1  high from start acceptance until done.
result  out  WIDTH  x^e mod M; valid while done is high, held until next start.
done  out  1  one-cycle completion pulse.
mul_start  out  1  one-cycle pulse launching a multiplication.
mul_a  out  WIDTH  multiplier operand a, registered.
mul_b  out  WIDTH  multiplier operand b, registered.
mul_m  out  WIDTH  modulus to multiplier, latched in_m.
mul_result  in  WIDTH  multiplier output, valid when mul_done is high.
mul_done  in  1  multiplier completion pulse.

Behaviour:
- Reset: state IDLE; busy, done and mul_start = 0; result, mul_a, mul_b, mul_m and internal registers = 0.
- IDLE + start: latch in_x, in_e, in_m, in_r, in_r2; set busy; bit index i = E_WIDTH-1. start in any other state is ignored.
- Multiplication handshake:
  - Each op drives mul_a and mul_b, then mul_start = 1 for exactly one cycle.
  - Operands stay stable until mul_done.
  - The controller waits an unbounded number of cycles for mul_done.
  - mul_result is captured on the mul_done cycle; the next op may start the following cycle.
  - mul_done arriving while no op is outstanding is ignored.
- States (each mul state = issue plus wait):
  - TO_MONT: xt = mont(x, r2); A = r.
  - SQUARE: A = mont(A, A).
  - MULT: A = mont(A, xt).
  - FROM_MONT: A = mont(A, 1).
  - FINISH: result = A; done = 1 for one cycle; busy = 0; go to IDLE.
- Transitions:
  - TO_MONT -> SQUARE.
  - SQUARE -> MULT if e[i] = 1, else next-bit.
  - MULT -> next-bit.
  - next-bit: if i == 0 go to FROM_MONT, else i-1 and go to SQUARE.
  - FROM_MONT -> FINISH.
- Op count: 2 + (bits processed) + popcount(e).
- e = 0: all squarings of R; result = 1.
- x = 0: result = 0.
- Results are exactly reduced (< M); the multiplier guarantees final subtraction.
- Reset mid-operation: abandon immediately to IDLE, outputs to reset values, no done. The multiplier shares the same reset.

Optional Feature:
- SKIP_LEADING_ZEROS_EN defined:
  - Adds a SCAN state after start, one cycle, using a priority encoder that sets i to the index of the MSB set in e.
  - Leading zero bits cost no squarings.
  - e = 0 goes TO_MONT -> FROM_MONT directly.
- Undefined: all E_WIDTH bits are processed.
- Result values are identical either way; only the op count and latency differ.

Decomposition:
- Shared package montgomery_pkg holds:
  - state enum encoding;
  - default WIDTH/E_WIDTH constants;
  - operand-select encoding (SEL_X, SEL_A, SEL_XT, SEL_ONE, SEL_R2).
- One natural sub-module: mont_mul_issue, which owns the mul_* handshake (pulse generation, operand hold, result capture, outstanding flag).

Test Plan:
- Bench setup: behavioural montgomery model with programmable latency 1..40 cycles; WIDTH = 512, E_WIDTH = 16; M = 13, r = 9, r2 = 3 throughout.
- x=2, e=10 -> result 10; exactly 8 mul_start pulses with SKIP_LEADING_ZEROS_EN, 20 without; one done pulse.
- x=5, e=1 -> 5. x=7, e=0 -> 1. x=0, e=5 -> 0.
- Back-to-back: start again the cycle after done, with x=3, e=65535 -> 3^65535 mod 13 = 3^3 mod 13 = 1. Also start pulsed while busy is ignored and the result is unchanged.
- Reset asserted during the 5th wait of x=2, e=10 -> next cycle IDLE, busy=0, no done. A late mul_done is ignored. A fresh run then yields 10.
- Randomised full-size run: 512-bit x, e, M from the python vector generator, with random multiplier latency -> result equals golden pow(x, e, M).

Source files
------------

// File: rtl/montgomery_pkg.sv
// Shared types and defaults for the Montgomery exponentiation controller.
package montgomery_pkg;

  localparam int DEF_WIDTH   = 512;
  localparam int DEF_E_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_TO_MONT,
    ST_SQUARE,
    ST_MULT,
    ST_FROM_MONT,
    ST_FINISH
  } state_t;

  typedef enum logic [2:0] {
    SEL_X,
    SEL_A,
    SEL_XT,
    SEL_ONE,
    SEL_R2
  } sel_t;

endpackage

// File: rtl/mont_mul_issue.sv
// Owns the multiplier handshake: operand registers, start pulse, outstanding flag.
module mont_mul_issue
  import montgomery_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             pending,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_done
);

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      pending   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      if (req && !pending) begin
        mul_a     <= req_a;
        mul_b     <= req_b;
        mul_start <= 1'b1;
        pending   <= 1'b1;
      end else if (mul_done && pending) begin
        pending <= 1'b0;
      end
    end
  end

  // A done pulse with nothing in flight is stray and must not reach the FSM.
  assign rsp_valid = mul_done & pending;
  assign rsp_data  = mul_result;

endmodule

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply modular exponentiation over an external
// Montgomery multiplier. Optional macro SKIP_LEADING_ZEROS_EN adds an MSB scan.
//
// state        | meaning
// IDLE         | waiting for start
// SCAN         | locate exponent MSB (SKIP_LEADING_ZEROS_EN only)
// TO_MONT      | xt = mont(x, r2); A = r
// SQUARE       | A = mont(A, A)
// MULT         | A = mont(A, xt)
// FROM_MONT    | A = mont(A, 1)
// FINISH       | publish result, pulse done
module montgomery_exp
  import montgomery_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int E_WIDTH = DEF_E_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_r2,
  output logic               busy,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic [WIDTH-1:0]   mul_m,
  input  logic [WIDTH-1:0]   mul_result,
  input  logic               mul_done
);

  localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_t             state;
  logic [WIDTH-1:0]   x_q, r_q, r2_q, m_q, a_q, xt_q;
  logic [E_WIDTH-1:0] e_q;
  logic [IW-1:0]      idx;
  sel_t               sel_a, sel_b;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               mul_state, req, pending, rsp_valid;
  logic [WIDTH-1:0]   rsp_data;
  logic               last_bit;

`ifdef SKIP_LEADING_ZEROS_EN
  logic e_zero_q;

  function automatic logic [IW-1:0] msb_idx(input logic [E_WIDTH-1:0] v);
    msb_idx = '0;
    for (int k = 0; k < E_WIDTH; k++)
      if (v[k]) msb_idx = IW'(k);
  endfunction
`endif

  assign mul_m     = m_q;
  assign last_bit  = (idx == '0);
  assign mul_state = (state == ST_TO_MONT) || (state == ST_SQUARE) ||
                     (state == ST_MULT)    || (state == ST_FROM_MONT);
  // Issue as soon as the previous op has retired; pending drops the cycle after capture.
  assign req       = mul_state && !pending;

  always_comb begin
    sel_a = SEL_A;
    sel_b = SEL_A;
    case (state)
      ST_TO_MONT:   begin sel_a = SEL_X; sel_b = SEL_R2; end
      ST_MULT:      sel_b = SEL_XT;
      ST_FROM_MONT: sel_b = SEL_ONE;
      default:      ;
    endcase
  end

  always_comb begin
    op_a = a_q;
    case (sel_a)
      SEL_X:   op_a = x_q;
      SEL_XT:  op_a = xt_q;
      SEL_ONE: op_a = WIDTH'(1);
      SEL_R2:  op_a = r2_q;
      default: op_a = a_q;
    endcase
  end

  always_comb begin
    op_b = a_q;
    case (sel_b)
      SEL_X:   op_b = x_q;
      SEL_XT:  op_b = xt_q;
      SEL_ONE: op_b = WIDTH'(1);
      SEL_R2:  op_b = r2_q;
      default: op_b = a_q;
    endcase
  end

  mont_mul_issue #(.WIDTH(WIDTH)) u_issue (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_a     (op_a),
    .req_b     (op_b),
    .pending   (pending),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_result(mul_result),
    .mul_done  (mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      x_q    <= '0;
      e_q    <= '0;
      r_q    <= '0;
      r2_q   <= '0;
      m_q    <= '0;
      a_q    <= '0;
      xt_q   <= '0;
      idx    <= '0;
`ifdef SKIP_LEADING_ZEROS_EN
      e_zero_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          x_q  <= in_x;
          e_q  <= in_e;
          m_q  <= in_m;
          r_q  <= in_r;
          r2_q <= in_r2;
          busy <= 1'b1;
          idx  <= IW'(E_WIDTH - 1);
`ifdef SKIP_LEADING_ZEROS_EN
          state <= ST_SCAN;
`else
          state <= ST_TO_MONT;
`endif
        end
`ifdef SKIP_LEADING_ZEROS_EN
        ST_SCAN: begin
          idx      <= msb_idx(e_q);
          e_zero_q <= (e_q == '0);
          state    <= ST_TO_MONT;
        end
`endif
        ST_TO_MONT: if (rsp_valid) begin
          xt_q <= rsp_data;
          a_q  <= r_q;
`ifdef SKIP_LEADING_ZEROS_EN
          state <= e_zero_q ? ST_FROM_MONT : ST_SQUARE;
`else
          state <= ST_SQUARE;
`endif
        end
        ST_SQUARE: if (rsp_valid) begin
          a_q <= rsp_data;
          if (e_q[idx])      state <= ST_MULT;
          else if (last_bit) state <= ST_FROM_MONT;
          else begin
            idx   <= idx - 1'b1;
            state <= ST_SQUARE;
          end
        end
        ST_MULT: if (rsp_valid) begin
          a_q <= rsp_data;
          if (last_bit) state <= ST_FROM_MONT;
          else begin
            idx   <= idx - 1'b1;
            state <= ST_SQUARE;
          end
        end
        ST_FROM_MONT: if (rsp_valid) begin
          a_q   <= rsp_data;
          state <= ST_FINISH;
        end
        ST_FINISH: begin
          result <= a_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
